// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between the ALU pipeline (source 0)
// and the multi-cycle mul/div/load unit (source 1); the winner is registered onto the write port.
module regfile_wb_arbiter #(
    parameter int RW = 5,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          s0_valid,
    input  logic [RW-1:0] s0_addr,
    input  logic [W-1:0]  s0_data,
    output logic          s0_ready,
    input  logic          s1_valid,
    input  logic [RW-1:0] s1_addr,
    input  logic [W-1:0]  s1_data,
    output logic          s1_ready,
    output logic          write_en,
    output logic [RW-1:0] write_addr,
    output logic [W-1:0]  write_data,
    output logic          last_grant
);

    logic          r_write_en;
    logic [RW-1:0] r_write_addr;
    logic [W-1:0]  r_write_data;
    logic          r_last_grant;

    logic          w_grant_vld;
    logic          w_grant_idx;
    logic [RW-1:0] w_grant_addr;
    logic [W-1:0]  w_grant_data;

    // Reset is kept out of this decode so it only reaches the flops as an async clear.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = 1'b0;
        if (!hold) begin
            if (s0_valid && s1_valid) begin
                w_grant_vld = 1'b1;
                w_grant_idx = ~r_last_grant;
            end else if (s0_valid) begin
                w_grant_vld = 1'b1;
                w_grant_idx = 1'b0;
            end else if (s1_valid) begin
                w_grant_vld = 1'b1;
                w_grant_idx = 1'b1;
            end
        end
    end

    assign w_grant_addr = w_grant_idx ? s1_addr : s0_addr;
    assign w_grant_data = w_grant_idx ? s1_data : s0_data;

    // While reset is held no source may believe it was accepted.
    assign s0_ready = rst & w_grant_vld & ~w_grant_idx;
    assign s1_ready = rst & w_grant_vld &  w_grant_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_write_en   <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
            r_last_grant <= 1'b1;
        end else begin
            // Writes to r0 are consumed but never reach the regfile.
            r_write_en <= w_grant_vld && (w_grant_addr != '0);
            if (w_grant_vld) begin
                r_write_addr <= w_grant_addr;
                r_write_data <= w_grant_data;
                r_last_grant <= w_grant_idx;
            end
        end
    end

    assign write_en   = r_write_en;
    assign write_addr = r_write_addr;
    assign write_data = r_write_data;
    assign last_grant = r_last_grant;

endmodule
